// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a 62256 32Kx8 SRAM.
// Each access is SETUP, STROBE_CYCLES of STROBE and HOLD; every SRAM-facing output is registered.
module sram_arbiter #(
  parameter int ADDR_WIDTH    = 15,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  output logic [7:0]            a_rdata,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic [7:0]            b_rdata,
  output logic                  b_ack,
  output logic                  sram_ncs,
  output logic                  sram_nwe,
  output logic                  sram_noe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_dout,
  output logic                  sram_doe,
  input  logic [7:0]            sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  last_b_q;
  logic                  gnt_b_q;
  logic                  we_q;
  logic                  ncs_q, nwe_q, noe_q, doe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            dout_q;
  logic [7:0]            a_rdata_q, b_rdata_q;
  logic                  a_ack_q, b_ack_q;

  logic                  gnt_b_d;
  logic                  win_we_d;
  logic [ADDR_WIDTH-1:0] win_addr_d;
  logic [7:0]            win_wdata_d;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    // On a tie the port that was not granted last wins; otherwise the lone requester wins.
    gnt_b_d     = (a_req && b_req) ? ~last_b_q : b_req;
    win_we_d    = gnt_b_d ? b_we    : a_we;
    win_addr_d  = gnt_b_d ? b_addr  : a_addr;
    win_wdata_d = gnt_b_d ? b_wdata : a_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      ncs_q     <= 1'b1;
      nwe_q     <= 1'b1;
      noe_q     <= 1'b1;
      doe_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            gnt_b_q  <= gnt_b_d;
            last_b_q <= gnt_b_d;
            we_q     <= win_we_d;
            addr_q   <= win_addr_d;
            if (win_we_d) dout_q <= win_wdata_d;
            doe_q    <= win_we_d;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          ncs_q   <= 1'b0;
          nwe_q   <= ~we_q;
          noe_q   <= we_q;
          cnt_q   <= CNT_LAST;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            ncs_q <= 1'b1;
            nwe_q <= 1'b1;
            noe_q <= 1'b1;
            // Read data is still driven by the SRAM on this edge since the strobes are registered.
            if (!we_q) begin
              if (gnt_b_q) b_rdata_q <= sram_din;
              else         a_rdata_q <= sram_din;
            end
            a_ack_q <= ~gnt_b_q;
            b_ack_q <= gnt_b_q;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          doe_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_ncs  = ncs_q;
  assign sram_nwe  = nwe_q;
  assign sram_noe  = noe_q;
  assign sram_doe  = doe_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with the default strobe length and one with STROBE_CYCLES=1,
// each attached to a simple 62256 behavioural model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // Instance 0: STROBE_CYCLES = 2
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ack, b_ack;
  logic        sram_ncs, sram_nwe, sram_noe, sram_doe;
  logic [14:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;

  // Instance 1: STROBE_CYCLES = 1
  logic        s1_a_req, s1_a_we, s1_b_req, s1_b_we;
  logic [14:0] s1_a_addr, s1_b_addr;
  logic [7:0]  s1_a_wdata, s1_b_wdata, s1_a_rdata, s1_b_rdata;
  logic        s1_a_ack, s1_b_ack;
  logic        s1_ncs, s1_nwe, s1_noe, s1_doe;
  logic [14:0] s1_addr;
  logic [7:0]  s1_dout, s1_din;

  sram_arbiter #(.ADDR_WIDTH(15), .STROBE_CYCLES(2)) dut (
    .clk(clk), .nrst(nrst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .sram_ncs(sram_ncs), .sram_nwe(sram_nwe), .sram_noe(sram_noe), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din)
  );

  sram_arbiter #(.ADDR_WIDTH(15), .STROBE_CYCLES(1)) dut1 (
    .clk(clk), .nrst(nrst),
    .a_req(s1_a_req), .a_we(s1_a_we), .a_addr(s1_a_addr), .a_wdata(s1_a_wdata), .a_rdata(s1_a_rdata), .a_ack(s1_a_ack),
    .b_req(s1_b_req), .b_we(s1_b_we), .b_addr(s1_b_addr), .b_wdata(s1_b_wdata), .b_rdata(s1_b_rdata), .b_ack(s1_b_ack),
    .sram_ncs(s1_ncs), .sram_nwe(s1_nwe), .sram_noe(s1_noe), .sram_addr(s1_addr),
    .sram_dout(s1_dout), .sram_doe(s1_doe), .sram_din(s1_din)
  );

  // 62256 models: write while ncs/nwe low with the bus driven, read data out while ncs/noe low.
  logic [7:0]  mem0 [0:32767];
  logic [7:0]  mem1 [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we)                                 mem0[pre_addr]  <= pre_data;
    else if (!sram_ncs && !sram_nwe && sram_doe) mem0[sram_addr] <= sram_dout;
  end
  always @(posedge clk) begin
    if (!s1_ncs && !s1_nwe && s1_doe) mem1[s1_addr] <= s1_dout;
  end
  assign sram_din = (!sram_ncs && !sram_noe) ? mem0[sram_addr] : 8'hxx;
  assign s1_din   = (!s1_ncs && !s1_noe)     ? mem1[s1_addr]   : 8'hxx;

  int vec_cnt     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-window trace statistics, cycle 1 being the cycle after the first observed edge.
  int          n_ncs, n_nwe, n_noe, n_doe, n_split, n_both;
  int          a_ack_cyc[$], b_ack_cyc[$];
  logic [7:0]  a_rd[$], b_rd[$];
  logic [14:0] addr_t [0:31];

  task automatic observe(input int n, input bit sel);
    logic ncs, nwe, noe, doe, aa, ba;
    n_ncs = 0; n_nwe = 0; n_noe = 0; n_doe = 0; n_split = 0; n_both = 0;
    a_ack_cyc.delete(); b_ack_cyc.delete(); a_rd.delete(); b_rd.delete();
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      ncs = sel ? s1_ncs   : sram_ncs;
      nwe = sel ? s1_nwe   : sram_nwe;
      noe = sel ? s1_noe   : sram_noe;
      doe = sel ? s1_doe   : sram_doe;
      aa  = sel ? s1_a_ack : a_ack;
      ba  = sel ? s1_b_ack : b_ack;
      if (!ncs) n_ncs++;
      if (!nwe) n_nwe++;
      if (!noe) n_noe++;
      if (doe)  n_doe++;
      if (ncs != (nwe & noe)) n_split++;
      if (aa && ba) n_both++;
      if (aa) begin a_ack_cyc.push_back(c); a_rd.push_back(sel ? s1_a_rdata : a_rdata); end
      if (ba) begin b_ack_cyc.push_back(c); b_rd.push_back(sel ? s1_b_rdata : b_rdata); end
      addr_t[c] = sel ? s1_addr : sram_addr;
    end
  endtask

  logic [14:0] rd_addr [0:2];
  logic [7:0]  rd_data [0:2];

  initial begin
    nrst = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    s1_a_req = 0; s1_a_we = 0; s1_a_addr = '0; s1_a_wdata = '0;
    s1_b_req = 0; s1_b_we = 0; s1_b_addr = '0; s1_b_wdata = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    rd_addr[0] = 15'h7FFF; rd_data[0] = 8'hAA;
    rd_addr[1] = 15'h0000; rd_data[1] = 8'h55;
    rd_addr[2] = 15'h4000; rd_data[2] = 8'hC3;

    // Preload the B read locations while the arbiter is held in reset.
    for (int i = 0; i < 3; i++) begin
      pre_we = 1; pre_addr = rd_addr[i]; pre_data = rd_data[i];
      @(posedge clk); #1;
    end
    pre_we = 0;

    check("rst_ncs", sram_ncs, 1);
    check("rst_nwe", sram_nwe, 1);
    check("rst_noe", sram_noe, 1);
    check("rst_doe", sram_doe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_acks", {a_ack, b_ack}, 0);

    // A write 0x1234 <- 0x42, granted on the first edge after reset release.
    nrst = 1;
    a_req = 1; a_we = 1; a_addr = 15'h1234; a_wdata = 8'h42;
    observe(5, 0);
    a_req = 0;
    check("wr_ncs_low", n_ncs, 2);
    check("wr_nwe_low", n_nwe, 2);
    check("wr_noe_low", n_noe, 0);
    check("wr_doe_high", n_doe, 4);
    check("wr_strobe_align", n_split, 0);
    check("wr_ack_count", a_ack_cyc.size(), 1);
    check("wr_ack_cycle", a_ack_cyc[0], 4);
    check("wr_b_ack", b_ack_cyc.size(), 0);
    check("wr_addr_setup", addr_t[1], 15'h1234);
    check("wr_addr_hold", addr_t[4], 15'h1234);
    check("wr_dout", sram_dout, 8'h42);
    check("wr_mem", mem0[15'h1234], 8'h42);
    check("wr_a_rdata", a_rdata, 0);

    // A read back 0x1234.
    a_req = 1; a_we = 0; a_addr = 15'h1234;
    observe(5, 0);
    a_req = 0;
    check("rd_doe_high", n_doe, 0);
    check("rd_noe_low", n_noe, 2);
    check("rd_nwe_low", n_nwe, 0);
    check("rd_ncs_low", n_ncs, 2);
    check("rd_ack_count", a_ack_cyc.size(), 1);
    check("rd_ack_cycle", a_ack_cyc[0], 4);
    check("rd_rdata_at_ack", a_rd[0], 8'h42);
    check("rd_b_rdata", b_rdata, 0);

    // B-only stream of three reads.
    for (int i = 0; i < 3; i++) begin
      b_req = 1; b_we = 0; b_addr = rd_addr[i];
      observe(5, 0);
      check("brd_ack_count", b_ack_cyc.size(), 1);
      check("brd_ack_cycle", b_ack_cyc[0], 4);
      check("brd_rdata", b_rd[0], rd_data[i]);
      check("brd_a_ack", a_ack_cyc.size(), 0);
    end
    b_req = 0;
    check("brd_a_rdata", a_rdata, 8'h42);

    // Both ports request continuously; last grant was B so A leads.
    a_req = 1; a_we = 1; a_addr = 15'h0001; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 15'h0002; b_wdata = 8'h22;
    observe(20, 0);
    a_req = 0; b_req = 0;
    check("rr_both_ack", n_both, 0);
    check("rr_a_count", a_ack_cyc.size(), 2);
    check("rr_b_count", b_ack_cyc.size(), 2);
    check("rr_a_ack1", a_ack_cyc[0], 4);
    check("rr_b_ack1", b_ack_cyc[0], 9);
    check("rr_a_ack2", a_ack_cyc[1], 14);
    check("rr_b_ack2", b_ack_cyc[1], 19);
    check("rr_addr1", addr_t[1], 15'h0001);
    check("rr_addr2", addr_t[6], 15'h0002);
    check("rr_addr3", addr_t[11], 15'h0001);
    check("rr_addr4", addr_t[16], 15'h0002);
    check("rr_mem1", mem0[15'h0001], 8'h11);
    check("rr_mem2", mem0[15'h0002], 8'h22);
    check("rr_a_rdata", a_rdata, 8'h42);
    check("rr_b_rdata", b_rdata, 8'hC3);

    // Reset asserted in the second STROBE cycle of a write.
    a_req = 1; a_we = 1; a_addr = 15'h0100; a_wdata = 8'hEE;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_ncs_before", sram_ncs, 0);
    nrst = 0;
    #1;
    check("mid_ncs", sram_ncs, 1);
    check("mid_nwe", sram_nwe, 1);
    check("mid_noe", sram_noe, 1);
    check("mid_doe", sram_doe, 0);
    check("mid_ack", {a_ack, b_ack}, 0);
    check("mid_rdata", {a_rdata, b_rdata}, 0);
    a_req = 0;
    observe(3, 0);
    check("mid_no_ack", a_ack_cyc.size() + b_ack_cyc.size(), 0);
    check("mid_no_strobe", n_ncs, 0);

    nrst = 1;
    a_req = 1; a_we = 0; a_addr = 15'h1234;
    observe(5, 0);
    a_req = 0;
    check("post_ack_count", a_ack_cyc.size(), 1);
    check("post_ack_cycle", a_ack_cyc[0], 4);
    check("post_rdata", a_rd[0], 8'h42);

    // STROBE_CYCLES = 1: write then read 0x2AAA.
    s1_a_req = 1; s1_a_we = 1; s1_a_addr = 15'h2AAA; s1_a_wdata = 8'h99;
    observe(4, 1);
    check("s1_wr_ncs_low", n_ncs, 1);
    check("s1_wr_nwe_low", n_nwe, 1);
    check("s1_wr_doe_high", n_doe, 3);
    check("s1_wr_ack_count", a_ack_cyc.size(), 1);
    check("s1_wr_ack_cycle", a_ack_cyc[0], 3);
    s1_a_we = 0;
    observe(4, 1);
    s1_a_req = 0;
    check("s1_rd_ncs_low", n_ncs, 1);
    check("s1_rd_noe_low", n_noe, 1);
    check("s1_rd_doe_high", n_doe, 0);
    check("s1_rd_ack_count", a_ack_cyc.size(), 1);
    check("s1_rd_ack_cycle", a_ack_cyc[0], 3);
    check("s1_rd_rdata", a_rd[0], 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the 62256 32Kx8 static RAM. Two requesters, port A (CPU side) and port B (secondary master, e.g. DMA or video fetch), each raise a request. The block grants one at a time, round-robin. It generates the SRAM `ncs`/`nwe`/`noe` strobe sequence and the address and data bus direction control. Read data is returned on a per-port register with a one-cycle acknowledge pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 15, SRAM address width (62256 = 15).
- `STROBE_CYCLES`, 2, cycles `ncs` (plus `nwe` or `noe`) stay low per access; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `nrst`  in  1  reset; clock is `clk`, reset is asynchronous and active-low.
- `a_req`  in  1  port A request; hold high until `a_ack`.
- `a_we`  in  1  port A: 1 = write, 0 = read.
- `a_addr`  in  ADDR_WIDTH  port A address.
- `a_wdata`  in  8  port A write data.
- `a_rdata`  out  8  port A read data; valid in `a_ack` cycle, held until the next A read completes.
- `a_ack`  out  1  port A one-cycle completion pulse.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_rdata`, `b_ack`: same as port A, for port B.
- `sram_ncs`  out  1  SRAM chip select, active-low.
- `sram_nwe`  out  1  SRAM write enable, active-low.
- `sram_noe`  out  1  SRAM output enable, active-low.
- `sram_addr`  out  ADDR_WIDTH  SRAM address.
- `sram_dout`  out  8  data driven toward SRAM.
- `sram_doe`  out  1  1 = drive `sram_dout` onto the bus. The top level tri-states the bus when this is 0.
- `sram_din`  in  8  data bus as read from SRAM.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: strobes high, `sram_doe`=0.
  - If a request is pending, latch the winner's addr/we/wdata into internal registers, then go to SETUP.
  - If no request is pending, stay in IDLE.
- SETUP (1 cycle): `sram_addr` = latched address, `ncs`/`nwe`/`noe` high. On a write, `sram_doe`=1 and `sram_dout` = latched data.
- STROBE (STROBE_CYCLES cycles): `ncs`=0.
  - Write: `nwe`=0, `noe`=1, `sram_doe`=1.
  - Read: `noe`=0, `nwe`=1, `sram_doe`=0.
  - Read data: on the clock edge that ends the last STROBE cycle, `sram_din` is captured into the granted port's `rdata`.
- HOLD (1 cycle): all strobes high, address held. On a write, `sram_doe` stays 1 for data hold time. The granted port's `ack`=1. Next state is IDLE.
- `sram_addr`/`sram_dout` keep their last values in IDLE. They change only on entry to SETUP.
- Arbitration: round-robin on a `last` flag.
  - Only one port requesting: that port wins.
  - Both requesting: the port not in `last` wins.
  - `last` updates on grant. Reset value = B, so A wins the first tie.
- Request sampling: requests are sampled only in IDLE. A request raised during another access waits.
- A port whose `req` drops mid-access still gets its access completed and its `ack` pulsed. The requester ignores that `ack`.
- Write accesses never modify `rdata`.
- Both ack outputs are never high in the same cycle.

## Timing
- Reset (async assert, any state): state=IDLE and `last`=B.
  - Outputs: `sram_ncs`=`sram_nwe`=`sram_noe`=1, `sram_doe`=0.
  - Cleared to 0: `sram_addr`, `sram_dout`, `a_rdata`, `b_rdata`, `a_ack`, `b_ack`.
- Reset mid-STROBE: strobes rise immediately and no `ack` is issued.
- Reset release: first grant possible on the first rising edge with `nrst`=1.
- Access latency:
  - Edge sampling req in IDLE → SETUP.
  - `ack` is high in cycle 2+STROBE_CYCLES after that edge (default: 4th cycle).
  - Service period = STROBE_CYCLES+3 cycles (default 5). Back-to-back requests complete every 5 cycles.
- Strobe ordering: `ncs` and `nwe`/`noe` fall together on entry to STROBE and rise together on entry to HOLD. Address is stable from SETUP through HOLD inclusive.
- Requester rule: req/addr/we/wdata stable from req rise until the edge on which `ack` is sampled high. The requester may drop req or issue a new request in the cycle after ack.

## Test plan
- Port A write addr 0x1234 data 0x42, bench uses the 62256 model:
  - `ncs` low exactly 2 cycles with `nwe` low, `sram_doe` high SETUP..HOLD.
  - `a_ack` pulses once, 4 cycles after grant edge.
- Port A read 0x1234 after the write:
  - Bus undriven (`sram_doe`=0) during the access, `noe` low 2 cycles.
  - `a_rdata`=0x42 in the `a_ack` cycle; `b_rdata` unchanged.
- `a_req` and `b_req` held high together, A writes 0x0001←0x11, B writes 0x0002←0x22:
  - Grants alternate A, B, A, B starting with A.
  - Acks 5 cycles apart, never both high.
- B-only stream of 3 reads from 0x7FFF, 0x0000, 0x4000 (preloaded 0xAA, 0x55, 0xC3):
  - `b_rdata` returns 0xAA, 0x55, 0xC3 in order; A outputs untouched.
- `nrst` pulled low in the 2nd STROBE cycle of a write:
  - Strobes high and `sram_doe`=0 in the same timestep, no ack.
  - After release, an A read completes normally.
- Bench with STROBE_CYCLES=1: write then read 0x2AAA←0x99.
  - `ncs` low 1 cycle per access, period 4 cycles, readback 0x99.
